// File: rtl/iter_divider_if.sv
// Handshake bundle for iter_divider.
//   master : the EX-stage issuer (drives operands, flush, out_ready)
//   slave  : the divider engine (drives in_ready, results, busy)
// Signals:
//   in_valid/in_ready    operand handshake
//   in_signed            1 = two's-complement operation
//   in_dividend          dividend (rj)
//   in_divisor           divisor (rk)
//   flush                cancel in-flight or unconsumed operation
//   out_valid/out_ready  result handshake
//   quotient/remainder   registered results
//   busy                 engine is iterating or fixing signs
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, flush, out_ready,
        input  in_ready, out_valid, quotient, remainder, busy
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, flush, out_ready,
        output in_ready, out_valid, quotient, remainder, busy
    );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle restoring integer divider, signed or unsigned per operation.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   div     iter_divider_if.slave handshake bundle (operands, flush,
//           results, busy)
// Divide-by-zero returns quotient = all ones, remainder = dividend, in one
// cycle. A result is held under backpressure until out_ready.
//
// state | meaning
// IDLE  | waiting for an operation
// CALC  | one restoring step per cycle on operand magnitudes
// FIX   | apply result signs
// DONE  | result valid, waiting for out_ready
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic          clk,
    input logic          resetn,
    iter_divider_if.slave div
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CALC = 4'b0010,
        FIX  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t           state, state_n;

    // The partial remainder stays below the divisor magnitude, so WIDTH bits
    // hold it; only the shifted/trial values need the extra bit.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;       // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] dsr;       // divisor magnitude
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             dsr_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign div.in_ready  = (state == IDLE) | ((state == DONE) & div.out_ready);
    assign accept        = div.in_valid & div.in_ready & ~div.flush;
    assign dsr_zero      = (div.in_divisor == '0);

    assign div.out_valid = (state == DONE);
    assign div.busy      = (state == CALC) | (state == FIX);
    assign div.quotient  = q_r;
    assign div.remainder = r_r;

    // MIN negates to itself, which is exactly its unsigned magnitude.
    assign abs_a = (div.in_signed && div.in_dividend[WIDTH-1]) ? -div.in_dividend
                                                                : div.in_dividend;
    assign abs_b = (div.in_signed && div.in_divisor[WIDTH-1])  ? -div.in_divisor
                                                                : div.in_divisor;

    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr};

    always_comb begin
        state_n = state;
        if (div.flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_n = dsr_zero ? DONE : CALC;
                end
                CALC: begin
                    if (cnt == CNT_W'(1)) state_n = FIX;
                end
                FIX: begin
                    state_n = DONE;
                end
                DONE: begin
                    if (div.out_ready) begin
                        if (accept) state_n = dsr_zero ? DONE : CALC;
                        else        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            rem   <= '0;
            dvd   <= abs_a;
            dsr   <= abs_b;
            cnt   <= CNT_W'(WIDTH);
            neg_q <= div.in_signed & (div.in_dividend[WIDTH-1] ^ div.in_divisor[WIDTH-1]);
            neg_r <= div.in_signed & div.in_dividend[WIDTH-1];
            if (dsr_zero) begin
                q_r <= '1;
                r_r <= div.in_dividend;
            end
        end else if (!div.flush && state == CALC) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                dvd <= {dvd[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                dvd <= {dvd[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
        end else if (!div.flush && state == FIX) begin
            // MIN / -1 wraps back to MIN here without special handling.
            q_r <= neg_q ? -dvd : dvd;
            r_r <= neg_r ? -rem : rem;
        end
    end

endmodule
